// File: rtl/delay_pipe_receiver_if.sv
// Bundle of request-credit, response-capture and downstream ready/valid signals
// for the fixed-latency delay pipe receiver.
interface delay_pipe_receiver_if #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             req_valid;
   logic             req_ready;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_bits;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_bits;
   logic [CW-1:0]    count;
   logic [CW-1:0]    inflight;
   logic             err_overflow;
   logic             err_timing;

   modport master (
      output req_valid, resp_valid, resp_bits, out_ready,
      input  req_ready, out_valid, out_bits, count, inflight, err_overflow, err_timing
   );

   modport slave (
      input  req_valid, resp_valid, resp_bits, out_ready,
      output req_ready, out_valid, out_bits, count, inflight, err_overflow, err_timing
   );
endinterface

// File: rtl/delay_pipe_receiver.sv
// Receive endpoint of a fixed-latency delay pipe: credit issue, response FIFO,
// and a shadow token pipe that flags responses arriving off-schedule.
module delay_pipe_receiver #(
   parameter int WIDTH   = 36,
   parameter int LATENCY = 5,
   parameter int DEPTH   = 8
) (
   input logic                 clock,
   input logic                 reset,
   delay_pipe_receiver_if.slave io
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW:0]   CREDITS = CW1'(DEPTH);

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [CW-1:0]      inflight;
   logic [LATENCY-1:0] tokens;
   logic               err_overflow;
   logic               err_timing;

   logic        req_ready;
   logic        accept;
   logic        expected;
   logic        full;
   logic        enq;
   logic        deq;
   logic        dec;
   logic [CW:0] committed;

   // NOTE: every signal gets its value on every pass through always_comb, so no latch can be inferred.
   always_comb begin
      committed = {1'b0, inflight} + {1'b0, count};
      req_ready = committed < CREDITS;
      accept    = io.req_valid && req_ready;
      expected  = tokens[LATENCY-1];
      full      = count == FULL;
      enq       = io.resp_valid && !full;
      deq       = (count != '0) && io.out_ready;
      dec       = io.resp_valid && (inflight != '0);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tokens       <= '0;
         count        <= '0;
         inflight     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         err_overflow <= 1'b0;
         err_timing   <= 1'b0;
      end else begin
         tokens[0] <= accept;
         for (int i = 1; i < LATENCY; i++) tokens[i] <= tokens[i-1];

         if (io.resp_valid != expected) err_timing <= 1'b1;
         if (io.resp_valid && full)     err_overflow <= 1'b1;

         if (enq) wr_ptr <= wr_ptr + AW'(1);
         if (deq) rd_ptr <= rd_ptr + AW'(1);

         unique case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // A response with nothing outstanding still lands in the FIFO but must not wrap inflight.
         unique case ({accept, dec})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; count gates what is visible.
   always_ff @(posedge clock) begin
      if (enq) mem[wr_ptr] <= io.resp_bits;
   end

   assign io.req_ready    = req_ready;
   assign io.out_valid    = count != '0;
   assign io.out_bits     = mem[rd_ptr];
   assign io.count        = count;
   assign io.inflight     = inflight;
   assign io.err_overflow = err_overflow;
   assign io.err_timing   = err_timing;
endmodule

// File: tb/tb_delay_pipe_receiver.sv
// Directed and randomized bench for delay_pipe_receiver against a queue-based
// reference model of credits, arrival schedule and FIFO contents.
module tb_delay_pipe_receiver;
   localparam int WIDTH   = 36;
   localparam int LATENCY = 5;
   localparam int DEPTH   = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   delay_pipe_receiver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   delay_pipe_receiver #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) u_dut (
      .clock (clock),
      .reset (reset),
      .io    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: FIFO contents, outstanding request times, sticky flags.
   logic [WIDTH-1:0] m_q[$];
   int               m_accepts[$];
   int               m_inflight;
   bit               m_err_ovf;
   bit               m_err_tim;

   // Environment: scheduled pipe responses keyed by arrival cycle.
   bit               auto_resp;
   logic [WIDTH-1:0] sched[int];
   logic [WIDTH-1:0] data_src[$];

   int               dut_accepts;
   bit               ready_dropped;
   logic [WIDTH-1:0] popped[$];
   int               pop_cycles[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit m_ready();
      return (m_inflight + m_q.size()) < DEPTH;
   endfunction

   function automatic logic [WIDTH-1:0] rand_data();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [WIDTH-1:0] next_data();
      if (data_src.size() > 0) return data_src.pop_front();
      return rand_data();
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_accepts.delete();
      m_inflight = 0;
      m_err_ovf  = 1'b0;
      m_err_tim  = 1'b0;
   endtask

   // One clock cycle: drive scheduled responses, compare outputs, advance model, clock edge.
   task automatic tick();
      bit acc, exp_arr, full, dec;
      if (auto_resp) begin
         bus.resp_valid = sched.exists(cyc);
         bus.resp_bits  = sched.exists(cyc) ? sched[cyc] : rand_data();
         if (sched.exists(cyc)) sched.delete(cyc);
      end

      check("req_ready", 64'(bus.req_ready), 64'(m_ready()));
      check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
      check("count", 64'(bus.count), 64'(m_q.size()));
      check("inflight", 64'(bus.inflight), 64'(m_inflight));
      check("err_overflow", 64'(bus.err_overflow), 64'(m_err_ovf));
      check("err_timing", 64'(bus.err_timing), 64'(m_err_tim));
      if (m_q.size() > 0) check("out_bits", 64'(bus.out_bits), 64'(m_q[0]));

      if (bus.req_valid && bus.req_ready) dut_accepts++;
      if (!bus.req_ready) ready_dropped = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
         popped.push_back(bus.out_bits);
         pop_cycles.push_back(cyc);
      end

      acc     = bus.req_valid && m_ready();
      exp_arr = (m_accepts.size() > 0) && (m_accepts[0] == cyc - LATENCY);
      if (exp_arr) void'(m_accepts.pop_front());
      if (bus.resp_valid !== exp_arr) m_err_tim = 1'b1;
      full = m_q.size() == DEPTH;
      dec  = bus.resp_valid && (m_inflight > 0);
      if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
      if (bus.resp_valid) begin
         if (!full) m_q.push_back(bus.resp_bits);
         else       m_err_ovf = 1'b1;
      end
      if (acc) begin
         m_accepts.push_back(cyc);
         if (auto_resp) sched[cyc + LATENCY] = next_data();
      end
      m_inflight = m_inflight + int'(acc) - int'(dec);

      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      bus.req_valid  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_bits  = '0;
      bus.out_ready  = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b0;
      auto_resp = 1'b1;
      do_reset();
      ticks(2);

      // Single request with a known payload.
      data_src.push_back(36'h9_ABCD_0123);
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      ticks(5);
      check("single_valid", 64'(bus.out_valid), 64'd1);
      check("single_bits", 64'(bus.out_bits), 64'h9_ABCD_0123);
      check("single_inflight", 64'(bus.inflight), 64'd0);
      check("single_err", 64'({bus.err_overflow, bus.err_timing}), 64'd0);
      bus.out_ready = 1'b1;
      ticks(2);

      // Credit exhaustion with a stalled consumer.
      do_reset();
      dut_accepts   = 0;
      bus.req_valid = 1'b1;
      ticks(20);
      check("exhaust_accepts", 64'(dut_accepts), 64'(DEPTH));
      check("exhaust_ready", 64'(bus.req_ready), 64'd0);
      check("exhaust_count", 64'(bus.count), 64'(DEPTH));
      check("exhaust_inflight", 64'(bus.inflight), 64'd0);
      check("exhaust_overflow", 64'(bus.err_overflow), 64'd0);
      bus.req_valid = 1'b0;

      // Back-to-back streaming with sequential data.
      do_reset();
      for (int i = 0; i < 20; i++) data_src.push_back(WIDTH'(i));
      popped.delete();
      pop_cycles.delete();
      ready_dropped = 1'b0;
      bus.out_ready = 1'b1;
      bus.req_valid = 1'b1;
      ticks(20);
      bus.req_valid = 1'b0;
      ticks(10);
      check("stream_len", 64'(popped.size()), 64'd20);
      for (int i = 0; i < popped.size(); i++) check("stream_order", 64'(popped[i]), 64'(i));
      if (pop_cycles.size() == 20)
         check("stream_span", 64'(pop_cycles[19] - pop_cycles[0]), 64'd19);
      check("stream_ready_held", 64'(ready_dropped), 64'd0);

      // Early response violates the fixed latency.
      do_reset();
      auto_resp     = 1'b0;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      ticks(3);
      bus.resp_valid = 1'b1;
      bus.resp_bits  = rand_data();
      tick();
      bus.resp_valid = 1'b0;
      check("timing_set", 64'(bus.err_timing), 64'd1);
      ticks(3);
      bus.resp_valid = 1'b1;
      tick();
      bus.resp_valid = 1'b0;
      tick();
      check("timing_sticky", 64'(bus.err_timing), 64'd1);

      // Forced overflow: nine responses with no credit and no consumer.
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         bus.resp_valid = 1'b1;
         bus.resp_bits  = rand_data();
         tick();
      end
      bus.resp_valid = 1'b0;
      check("overflow_flag", 64'(bus.err_overflow), 64'd1);
      check("overflow_count", 64'(bus.count), 64'(DEPTH));
      bus.out_ready = 1'b1;
      ticks(DEPTH + 2);

      // Asynchronous reset with three buffered and two in flight.
      do_reset();
      auto_resp     = 1'b1;
      bus.req_valid = 1'b1;
      ticks(5);
      bus.req_valid = 1'b0;
      ticks(3);
      check("pre_reset_count", 64'(bus.count), 64'd3);
      check("pre_reset_inflight", 64'(bus.inflight), 64'd2);
      reset = 1'b1;
      #1;
      check("async_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_count", 64'(bus.count), 64'd0);
      check("async_inflight", 64'(bus.inflight), 64'd0);
      check("async_req_ready", 64'(bus.req_ready), 64'd1);
      reset = 1'b0;
      model_reset();
      #1;
      ticks(3);
      check("stale_timing", 64'(bus.err_timing), 64'd1);

      // Randomized legal traffic.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         bus.req_valid = $urandom_range(0, 3) != 0;
         bus.out_ready = $urandom_range(0, 2) != 0;
         tick();
      end
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      ticks(LATENCY + DEPTH + 4);
      check("rand_errors", 64'({bus.err_overflow, bus.err_timing}), 64'd0);
      check("rand_drained", 64'(bus.count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
